// File: rtl/mips_pkg.sv
// Shared encodings for the 8-bit MIPS datapath:
// ALU control codes, ALUOp classes and R-type funct fields.
package mips_pkg;

   localparam logic [3:0] ALU_AND = 4'd0;
   localparam logic [3:0] ALU_OR  = 4'd1;
   localparam logic [3:0] ALU_ADD = 4'd2;
   localparam logic [3:0] ALU_SUB = 4'd6;
   localparam logic [3:0] ALU_SLT = 4'd7;
   localparam logic [3:0] ALU_NOR = 4'd12;
   localparam logic [3:0] ALU_ILL = 4'd15;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [1:0] ALUOP_OR    = 2'b11;

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;
   localparam logic [5:0] FUNCT_NOR = 6'b100111;

endpackage

// File: rtl/mips_alu_control.sv
// Combinational ALU control decode: (ALUOp, funct) -> alu_ctl.
// Unknown R-type funct codes map to ALU_ILL and raise illegal_o.
module mips_alu_control
   import mips_pkg::*;
(
   input  logic [1:0] alu_op_i,
   input  logic [5:0] funct_i,
   output logic [3:0] alu_ctl_o,
   output logic       illegal_o
);

   always_comb begin
      alu_ctl_o = ALU_ADD;
      illegal_o = 1'b0;
      unique case (alu_op_i)
         ALUOP_ADD: alu_ctl_o = ALU_ADD;
         ALUOP_SUB: alu_ctl_o = ALU_SUB;
         ALUOP_OR:  alu_ctl_o = ALU_OR;
         default: begin
            case (funct_i)
               FUNCT_ADD: alu_ctl_o = ALU_ADD;
               FUNCT_SUB: alu_ctl_o = ALU_SUB;
               FUNCT_AND: alu_ctl_o = ALU_AND;
               FUNCT_OR:  alu_ctl_o = ALU_OR;
               FUNCT_SLT: alu_ctl_o = ALU_SLT;
               FUNCT_NOR: alu_ctl_o = ALU_NOR;
               default: begin
                  alu_ctl_o = ALU_ILL;
                  illegal_o = 1'b1;
               end
            endcase
         end
      endcase
   end

endmodule

// File: rtl/mips_id_ex_stage.sv
// ID/EX pipeline register: decode, operand forwarding, stall/flush,
// and operand refresh from MEM/WB while the EX slot is held.
module mips_id_ex_stage
   import mips_pkg::*;
#(
   parameter int DW = 8,
   parameter int RW = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          stall,
   input  logic          flush,
   input  logic          id_valid,
   input  logic [1:0]    id_alu_op,
   input  logic [5:0]    id_funct,
   input  logic [DW-1:0] id_rs_data,
   input  logic [DW-1:0] id_rt_data,
   input  logic [DW-1:0] id_imm,
   input  logic          id_alu_src,
   input  logic [RW-1:0] id_rs,
   input  logic [RW-1:0] id_rt,
   input  logic [RW-1:0] id_rd,
   input  logic          id_reg_dst,
   input  logic          id_reg_write,
   input  logic          mem_reg_write,
   input  logic [RW-1:0] mem_rd,
   input  logic [DW-1:0] mem_result,
   input  logic          wb_reg_write,
   input  logic [RW-1:0] wb_rd,
   input  logic [DW-1:0] wb_result,
   output logic          ex_valid,
   output logic [3:0]    ex_alu_ctl,
   output logic [DW-1:0] ex_a,
   output logic [DW-1:0] ex_b,
   output logic [RW-1:0] ex_dest,
   output logic          ex_reg_write,
   output logic          ex_illegal
);

   logic [3:0]    dec_ctl;
   logic          dec_ill;

   logic          valid_q, valid_d;
   logic [3:0]    ctl_q, ctl_d;
   logic [DW-1:0] a_q, a_d;
   logic [DW-1:0] b_q, b_d;
   logic [RW-1:0] dest_q, dest_d;
   logic          rw_q, rw_d;
   logic          ill_q, ill_d;
   logic [RW-1:0] rs_q, rs_d;
   logic [RW-1:0] rt_q, rt_d;
   logic          src_q, src_d;

   mips_alu_control u_alu_control (
      .alu_op_i  (id_alu_op),
      .funct_i   (id_funct),
      .alu_ctl_o (dec_ctl),
      .illegal_o (dec_ill)
   );

   // MEM is the younger producer, so it wins over WB; r0 never forwards.
   function automatic logic [DW-1:0] fwd(
      input logic [RW-1:0] s,
      input logic [DW-1:0] dflt,
      input logic          m_we,
      input logic [RW-1:0] m_rd,
      input logic [DW-1:0] m_res,
      input logic          w_we,
      input logic [RW-1:0] w_rd,
      input logic [DW-1:0] w_res
   );
      logic nz;
      nz = (s != '0);
      if (m_we && m_rd == s && nz)      fwd = m_res;
      else if (w_we && w_rd == s && nz) fwd = w_res;
      else                              fwd = dflt;
   endfunction

   always_comb begin
      valid_d = valid_q;
      ctl_d   = ctl_q;
      a_d     = a_q;
      b_d     = b_q;
      dest_d  = dest_q;
      rw_d    = rw_q;
      ill_d   = ill_q;
      rs_d    = rs_q;
      rt_d    = rt_q;
      src_d   = src_q;
      if (flush || (!stall && !id_valid)) begin
         valid_d = 1'b0;
         ctl_d   = '0;
         a_d     = '0;
         b_d     = '0;
         dest_d  = '0;
         rw_d    = 1'b0;
         ill_d   = 1'b0;
         rs_d    = '0;
         rt_d    = '0;
         src_d   = 1'b0;
      end else if (stall) begin
         if (valid_q) begin
            a_d = fwd(rs_q, a_q, mem_reg_write, mem_rd,
                      mem_result, wb_reg_write, wb_rd, wb_result);
            if (!src_q)
               b_d = fwd(rt_q, b_q, mem_reg_write, mem_rd,
                         mem_result, wb_reg_write, wb_rd, wb_result);
         end
      end else begin
         valid_d = 1'b1;
         ctl_d   = dec_ctl;
         a_d     = fwd(id_rs, id_rs_data, mem_reg_write, mem_rd,
                       mem_result, wb_reg_write, wb_rd, wb_result);
         b_d     = id_alu_src ? id_imm :
                   fwd(id_rt, id_rt_data, mem_reg_write, mem_rd,
                       mem_result, wb_reg_write, wb_rd, wb_result);
         dest_d  = id_reg_dst ? id_rd : id_rt;
         rw_d    = id_reg_write & ~dec_ill;
         ill_d   = dec_ill;
         rs_d    = id_rs;
         rt_d    = id_rt;
         src_d   = id_alu_src;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         ctl_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         dest_q  <= '0;
         rw_q    <= 1'b0;
         ill_q   <= 1'b0;
         rs_q    <= '0;
         rt_q    <= '0;
         src_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         ctl_q   <= ctl_d;
         a_q     <= a_d;
         b_q     <= b_d;
         dest_q  <= dest_d;
         rw_q    <= rw_d;
         ill_q   <= ill_d;
         rs_q    <= rs_d;
         rt_q    <= rt_d;
         src_q   <= src_d;
      end
   end

   assign ex_valid     = valid_q;
   assign ex_alu_ctl   = ctl_q;
   assign ex_a         = a_q;
   assign ex_b         = b_q;
   assign ex_dest      = dest_q;
   assign ex_reg_write = rw_q;
   assign ex_illegal   = ill_q;

endmodule

// File: tb/tb_mips_id_ex_stage.sv
// Scoreboard bench for mips_id_ex_stage: directed cases, then
// randomized traffic against a behavioural reference model.
module tb_mips_id_ex_stage;

   localparam int DW = 8;
   localparam int RW = 5;

   typedef struct {
      logic          valid;
      logic [3:0]    ctl;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [RW-1:0] dest;
      logic          rw;
      logic          ill;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset, stall, flush, id_valid;
   logic [1:0]    id_alu_op;
   logic [5:0]    id_funct;
   logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
   logic          id_alu_src, id_reg_dst, id_reg_write;
   logic [RW-1:0] id_rs, id_rt, id_rd;
   logic          mem_reg_write, wb_reg_write;
   logic [RW-1:0] mem_rd, wb_rd;
   logic [DW-1:0] mem_result, wb_result;

   logic          ex_valid, ex_reg_write, ex_illegal;
   logic [3:0]    ex_alu_ctl;
   logic [DW-1:0] ex_a, ex_b;
   logic [RW-1:0] ex_dest;

   exp_t          sb_q[$];
   exp_t          m;
   logic [RW-1:0] m_rs, m_rt;
   logic          m_src;
   int            n_pass = 0;
   int            n_tot  = 0;
   int            cyc    = 0;

   mips_id_ex_stage #(.DW(DW), .RW(RW)) dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .id_valid(id_valid), .id_alu_op(id_alu_op), .id_funct(id_funct),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
      .id_alu_src(id_alu_src), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
      .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
      .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
      .ex_valid(ex_valid), .ex_alu_ctl(ex_alu_ctl), .ex_a(ex_a), .ex_b(ex_b),
      .ex_dest(ex_dest), .ex_reg_write(ex_reg_write), .ex_illegal(ex_illegal)
   );

   always #5 clk = ~clk;

   // Reference: ALU control table as listed for the ALU.
   function automatic int ref_ctl(input logic [1:0] op, input logic [5:0] f);
      if (op == 2'd0) return 2;
      if (op == 2'd1) return 6;
      if (op == 2'd3) return 1;
      case (f)
         6'd32:   return 2;
         6'd34:   return 6;
         6'd36:   return 0;
         6'd37:   return 1;
         6'd42:   return 7;
         6'd39:   return 12;
         default: return 15;
      endcase
   endfunction

   function automatic logic [DW-1:0] ref_src(input logic [RW-1:0] s,
                                             input logic [DW-1:0] rf);
      if (s == 0) return rf;
      if (mem_reg_write && mem_rd == s) return mem_result;
      if (wb_reg_write && wb_rd == s) return wb_result;
      return rf;
   endfunction

   function automatic exp_t bubble();
      exp_t e;
      e.valid = 0; e.ctl = 0; e.a = 0; e.b = 0;
      e.dest = 0; e.rw = 0; e.ill = 0;
      return e;
   endfunction

   task automatic model_step();
      int c;
      if (reset) begin
         m = bubble(); m_rs = 0; m_rt = 0; m_src = 0;
      end else if (flush) begin
         m = bubble();
      end else if (stall) begin
         if (m.valid) begin
            m.a = ref_src(m_rs, m.a);
            if (!m_src) m.b = ref_src(m_rt, m.b);
         end
      end else if (id_valid) begin
         c       = ref_ctl(id_alu_op, id_funct);
         m.valid = 1;
         m.ctl   = 4'(c);
         m.ill   = (c == 15);
         m.a     = ref_src(id_rs, id_rs_data);
         m.b     = id_alu_src ? id_imm : ref_src(id_rt, id_rt_data);
         m.dest  = id_reg_dst ? id_rd : id_rt;
         m.rw    = id_reg_write && (c != 15);
         m_rs = id_rs; m_rt = id_rt; m_src = id_alu_src;
      end else begin
         m = bubble();
      end
      sb_q.push_back(m);
   endtask

   task automatic idle();
      reset = 0; stall = 0; flush = 0; id_valid = 0;
      id_alu_op = 0; id_funct = 0; id_rs_data = 0; id_rt_data = 0;
      id_imm = 0; id_alu_src = 0; id_rs = 0; id_rt = 0; id_rd = 0;
      id_reg_dst = 0; id_reg_write = 0;
      mem_reg_write = 0; mem_rd = 0; mem_result = 0;
      wb_reg_write = 0; wb_rd = 0; wb_result = 0;
   endtask

   // Push expectation for the coming edge, then move to the next negedge.
   task automatic step();
      model_step();
      @(negedge clk);
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL cyc%0d %s: got %0h expected %0h", cyc, nm, act, exp);
   endtask

   // Monitor: one expectation per clock edge once stimulus has begun.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("valid", int'(ex_valid), int'(e.valid));
            chk("alu_ctl", int'(ex_alu_ctl), int'(e.ctl));
            chk("a", int'(ex_a), int'(e.a));
            chk("b", int'(ex_b), int'(e.b));
            chk("dest", int'(ex_dest), int'(e.dest));
            chk("reg_write", int'(ex_reg_write), int'(e.rw));
            chk("illegal", int'(ex_illegal), int'(e.ill));
         end
      end
   end

   initial begin
      logic [5:0] legal [6];
      legal[0] = 6'd32; legal[1] = 6'd34; legal[2] = 6'd36;
      legal[3] = 6'd37; legal[4] = 6'd42; legal[5] = 6'd39;
      m = bubble(); m_rs = 0; m_rt = 0; m_src = 0;
      idle();
      @(negedge clk);

      // Reset dominates a valid instruction
      reset = 1; id_valid = 1; id_reg_write = 1; id_alu_op = 2'b10;
      id_funct = 6'd32; id_rs_data = 8'h11; id_rt_data = 8'h22;
      step(); step();
      idle();

      // R-type sub
      id_valid = 1; id_alu_op = 2'b10; id_funct = 6'b100010;
      id_rs_data = 9; id_rt_data = 4; id_reg_dst = 1; id_rd = 3;
      id_rs = 1; id_rt = 2; id_reg_write = 1;
      step();

      // MEM beats WB on rs
      id_rs = 5; mem_reg_write = 1; mem_rd = 5; mem_result = 8'h20;
      wb_reg_write = 1; wb_rd = 5; wb_result = 8'h30;
      step();
      // r0 never forwards
      id_rs = 0; mem_rd = 0; wb_rd = 0; id_rs_data = 8'h55;
      step();
      idle();

      // Stall refresh of rt from WB
      id_valid = 1; id_alu_op = 2'b10; id_funct = 6'd37; id_rs = 4;
      id_rt = 7; id_rs_data = 8'h01; id_rt_data = 8'h11; id_reg_write = 1;
      step();
      idle();
      stall = 1; id_valid = 1; id_rt_data = 8'h99;
      wb_reg_write = 1; wb_rd = 7; wb_result = 8'hAA;
      step();
      idle();

      // Stall+flush gives a bubble, then an illegal funct
      stall = 1; flush = 1; id_valid = 1; id_reg_write = 1;
      step();
      idle();
      id_valid = 1; id_alu_op = 2'b10; id_funct = 6'b000000;
      id_reg_write = 1; id_rs_data = 3;
      step();
      idle();

      // Immediate is never overridden; lw/sw decode as add
      id_valid = 1; id_alu_op = 2'b00; id_alu_src = 1; id_imm = 8'h7F;
      id_rt = 2; id_rt_data = 8'h05; mem_reg_write = 1; mem_rd = 2;
      mem_result = 8'hEE; id_reg_write = 1;
      step();
      idle();

      // Randomized traffic with a small register window for frequent hits
      for (int i = 0; i < 600; i++) begin
         reset         = ($urandom_range(0, 39) == 0);
         flush         = ($urandom_range(0, 9) == 0);
         stall         = ($urandom_range(0, 3) == 0);
         id_valid      = ($urandom_range(0, 3) != 0);
         id_alu_op     = 2'($urandom_range(0, 3));
         id_funct      = ($urandom_range(0, 4) == 0) ? 6'($urandom)
                         : legal[$urandom_range(0, 5)];
         id_rs_data    = 8'($urandom);
         id_rt_data    = 8'($urandom);
         id_imm        = 8'($urandom);
         id_alu_src    = 1'($urandom);
         id_rs         = 5'($urandom_range(0, 3));
         id_rt         = 5'($urandom_range(0, 3));
         id_rd         = 5'($urandom);
         id_reg_dst    = 1'($urandom);
         id_reg_write  = 1'($urandom);
         mem_reg_write = 1'($urandom);
         mem_rd        = 5'($urandom_range(0, 3));
         mem_result    = 8'($urandom);
         wb_reg_write  = 1'($urandom);
         wb_rd         = 5'($urandom_range(0, 3));
         wb_result     = 8'($urandom);
         step();
      end
      idle();
      @(posedge clk);
      #2;
      n_tot++;
      if (sb_q.size() == 0) n_pass++;
      else $display("FAIL drain: got %0d pending expected 0", sb_q.size());
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
